// File: rtl/sap1_hw_sequencer.sv
// Hardwired SAP-1 controller-sequencer: negedge state machine driving the
// 12-bit control word {Lo,Lb,La,Su,Ea,Eu,Cp,Ep,Lm,CE,Li,Ei}.
// Ports: clk, CLR (async, active-high), run, step, i_opcode[3:0] in;
//        control_word[11:0], t_state[5:0] (one-hot, bit0=T1), halted,
//        instr_done, illegal (sticky) out.
module sap1_hw_sequencer (
   input  logic        clk,
   input  logic        CLR,
   input  logic        run,
   input  logic        step,
   input  logic [3:0]  i_opcode,
   output logic [11:0] control_word,
   output logic [5:0]  t_state,
   output logic        halted,
   output logic        instr_done,
   output logic        illegal
);

   typedef enum logic [2:0] {
      IDLE, T1, T2, T3, T4, T5, T6, HALT
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     st, nx;
   state_t     after_last;
   logic [3:0] op_q;
   logic       op_known;
   logic       op_hlt;

   // The IR is loaded at the posedge inside T3, so the raw opcode is
   // valid for the whole second half of T3 and drives the T3 branch.
   assign op_known = (i_opcode == OP_LDA) || (i_opcode == OP_ADD) ||
                     (i_opcode == OP_SUB) || (i_opcode == OP_OUT);
   assign op_hlt   = (i_opcode == OP_HLT);
   assign after_last = run ? T1 : IDLE;

   always_ff @(negedge clk or posedge CLR) begin
      if (CLR) begin
         st      <= IDLE;
         op_q    <= 4'h0;
         illegal <= 1'b0;
      end else begin
         st <= nx;
         if (st == T3) begin
            op_q <= i_opcode;
            if (!op_known && !op_hlt)
               illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      nx           = st;
      control_word = 12'h000;
      t_state      = 6'b000000;
      halted       = 1'b0;
      instr_done   = 1'b0;
      unique case (st)
         IDLE: begin
            if (run || step)
               nx = T1;
         end
         T1: begin
            control_word = 12'h018;
            t_state      = 6'b000001;
            nx           = T2;
         end
         T2: begin
            control_word = 12'h020;
            t_state      = 6'b000010;
            nx           = T3;
         end
         T3: begin
            control_word = 12'h006;
            t_state      = 6'b000100;
            if (op_hlt) begin
               nx = HALT;
            end else if (op_known) begin
               nx = T4;
            end else begin
               // undefined opcode: the fetch alone is the instruction
               instr_done = 1'b1;
               nx         = after_last;
            end
         end
         T4: begin
            t_state = 6'b001000;
            if (op_q == OP_OUT) begin
               control_word = 12'h880;
               instr_done   = 1'b1;
               nx           = after_last;
            end else begin
               control_word = 12'h009;
               nx           = T5;
            end
         end
         T5: begin
            t_state = 6'b010000;
            if (op_q == OP_LDA) begin
               control_word = 12'h204;
               instr_done   = 1'b1;
               nx           = after_last;
            end else begin
               control_word = 12'h404;
               nx           = T6;
            end
         end
         T6: begin
            t_state      = 6'b100000;
            control_word = (op_q == OP_SUB) ? 12'h340 : 12'h240;
            instr_done   = 1'b1;
            nx           = after_last;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sap1_hw_sequencer.sv
// Self-checking bench for sap1_hw_sequencer: directed scenarios followed by
// random run/step/opcode/CLR traffic, compared against an instruction model.
module tb_sap1_hw_sequencer;

   logic        clk = 1'b0;
   logic        CLR = 1'b1;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic [3:0]  i_opcode = 4'h0;
   logic [11:0] control_word;
   logic [5:0]  t_state;
   logic        halted;
   logic        instr_done;
   logic        illegal;

   int vectors = 0;
   int errs = 0;

   sap1_hw_sequencer dut (
      .clk          (clk),
      .CLR          (CLR),
      .run          (run),
      .step         (step),
      .i_opcode     (i_opcode),
      .control_word (control_word),
      .t_state      (t_state),
      .halted       (halted),
      .instr_done   (instr_done),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   // Instruction-level model: which T step of which instruction we are in.
   bit       m_idle = 1'b1;
   bit       m_halt = 1'b0;
   bit       m_ill  = 1'b0;
   int       m_k    = 0;
   bit [3:0] m_op   = 4'h0;

   function automatic int ilen(input bit [3:0] op);
      case (op)
         4'h0:    return 5;
         4'h1:    return 6;
         4'h2:    return 6;
         4'hE:    return 4;
         4'hF:    return 0;
         default: return 3;
      endcase
   endfunction

   function automatic bit [11:0] iword(input bit [3:0] op, input int k);
      case (k)
         1: return 12'h018;
         2: return 12'h020;
         3: return 12'h006;
         4: return (op == 4'hE) ? 12'h880 : 12'h009;
         5: return (op == 4'h0) ? 12'h204 : 12'h404;
         6: return (op == 4'h2) ? 12'h340 : 12'h240;
         default: return 12'h000;
      endcase
   endfunction

   always @(negedge clk or posedge CLR) begin
      if (CLR) begin
         m_idle = 1'b1;
         m_halt = 1'b0;
         m_k    = 0;
         m_ill  = 1'b0;
      end else if (!m_halt) begin
         if (m_idle) begin
            if (run || step) begin
               m_idle = 1'b0;
               m_k    = 1;
            end
         end else begin
            if (m_k == 3) begin
               m_op = i_opcode;
               if (m_op == 4'hF)
                  m_halt = 1'b1;
               else if (ilen(m_op) == 3)
                  m_ill = 1'b1;
            end
            if (!m_halt) begin
               if (m_k == ilen(m_op)) begin
                  if (run) begin
                     m_k = 1;
                  end else begin
                     m_idle = 1'b1;
                     m_k    = 0;
                  end
               end else begin
                  m_k++;
               end
            end
         end
      end
   end

   task automatic check();
      bit [11:0] e_cw;
      bit [5:0]  e_t;
      bit        e_h;
      bit        e_d;
      bit [3:0]  dop;
      e_cw = 12'h000;
      e_t  = 6'd0;
      e_h  = m_halt;
      e_d  = 1'b0;
      if (!m_halt && !m_idle) begin
         dop  = (m_k <= 3) ? i_opcode : m_op;
         e_cw = iword(m_op, m_k);
         e_t  = 6'd1 << (m_k - 1);
         e_d  = (ilen(dop) == m_k);
      end
      vectors++;
      assert (control_word === e_cw) else begin
         errs++;
         $error("FAIL cw obs=%h exp=%h", control_word, e_cw);
      end
      assert (t_state === e_t) else begin
         errs++;
         $error("FAIL t_state obs=%b exp=%b", t_state, e_t);
      end
      assert (halted === e_h) else begin
         errs++;
         $error("FAIL halted obs=%b exp=%b", halted, e_h);
      end
      assert (instr_done === e_d) else begin
         errs++;
         $error("FAIL instr_done obs=%b exp=%b", instr_done, e_d);
      end
      assert (illegal === m_ill) else begin
         errs++;
         $error("FAIL illegal obs=%b exp=%b", illegal, m_ill);
      end
   endtask

   task automatic tick(input bit r, input bit s, input bit [3:0] op);
      @(posedge clk);
      check();
      #1;
      run      = r;
      step     = s;
      i_opcode = op;
   endtask

   // Pulse CLR mid-cycle and check the asynchronous effect right away.
   task automatic do_clr();
      @(posedge clk);
      check();
      #1 CLR = 1'b1;
      #1 check();
      assert (illegal === 1'b0) else begin
         errs++;
         $error("FAIL clr_illegal obs=%b exp=0", illegal);
      end
      @(posedge clk);
      check();
      #1 CLR = 1'b0;
   endtask

   initial begin
      bit [3:0] ops[6];
      ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h5, 4'hF};
      #1;
      CLR = 1'b1;
      #20;
      check();
      CLR = 1'b0;

      // LDA then ADD back to back
      run = 1'b1;
      i_opcode = 4'h0;
      repeat (5) tick(1, 0, 4'h0);
      repeat (6) tick(1, 0, 4'h1);
      // SUB then OUT
      repeat (6) tick(1, 0, 4'h2);
      repeat (5) tick(1, 0, 4'hE);
      // undefined opcode, then valid ones with illegal sticky
      repeat (3) tick(1, 0, 4'h5);
      repeat (8) tick(1, 0, 4'h0);
      // ADD, then CLR mid-instruction
      repeat (8) tick(1, 0, 4'h1);
      do_clr();
      repeat (4) tick(1, 0, 4'hF);
      // HALT holds with run high and step pulsing
      for (int i = 0; i < 20; i++)
         tick(1, i[0], 4'h0);
      do_clr();
      // single step of ADD, opcode changing after the fetch
      tick(0, 0, 4'h1);
      repeat (6) tick(0, 0, 4'h1);
      tick(0, 1, 4'h1);
      tick(0, 0, 4'h1);
      tick(0, 0, 4'h1);
      tick(0, 0, 4'h1);
      for (int i = 0; i < 12; i++)
         tick(0, 0, 4'(i + 3));
      // step held high: one instruction per IDLE visit
      repeat (15) tick(0, 1, 4'hE);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 150) == 0 || (m_halt && $urandom_range(0, 8) == 0))
            do_clr();
         else
            tick($urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 9) == 0) ? ops[5] :
                 ops[$urandom_range(0, 4)]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
